// File: rtl/alt_cal_dprio_ser_sv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alt_cal_sv_pkg : shared types and frame helpers for serial DPRIO     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alt_cal_sv_pkg;

   localparam int ST_W   = 2;
   localparam int OP_W   = 2;
   localparam int PRT_W  = 5;
   localparam int DEV_W  = 5;
   localparam int TA_W   = 2;
   localparam int DATA_W = 16;
   localparam int c_TAIL_W = ST_W + OP_W + PRT_W + DEV_W + TA_W + DATA_W;

   localparam logic [OP_W-1:0] OP_ADDR = 2'b00;
   localparam logic [OP_W-1:0] OP_WR   = 2'b01;
   localparam logic [OP_W-1:0] OP_RD   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR_FRM = 3'd1,
      ST_GAP      = 3'd2,
      ST_DATA_FRM = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   // Everything after the preamble. Read frames release the line (all 1s)
   // through TA and DATA so the transceiver can drive dprioout.
   function automatic logic [c_TAIL_W-1:0] frame_tail(
      input logic [OP_W-1:0]   op,
      input logic [PRT_W-1:0]  prtad,
      input logic [DATA_W-1:0] data
   );
      logic [TA_W-1:0]   ta;
      logic [DATA_W-1:0] d;
      ta = (op == OP_RD) ? 2'b11 : 2'b10;
      d  = (op == OP_RD) ? 16'hFFFF : data;
      return {2'b00, op, prtad, 5'b00000, ta, d};
   endfunction

   // n = bits remaining in the frame, including the one being selected.
   function automatic logic frame_bit(
      input logic [c_TAIL_W-1:0] tail,
      input logic [6:0]          n
   );
      logic b;
      b = 1'b1;
      if ((n != 7'd0) && (n <= 7'(c_TAIL_W)))
         b = tail[5'(n - 7'd1)];
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alt_cal_dprio_ser_sv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alt_cal_dprio_ser_sv_if : calibration-controller request bus         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alt_cal_dprio_ser_sv_if;
   import alt_cal_sv_pkg::*;

   logic [15:0] dprio_addr;
   logic [15:0] dprio_dataout;
   logic        dprio_rden;
   logic        dprio_wren;
   logic [8:0]  quad_addr;
   logic        dprio_busy;
   logic [15:0] dprio_datain;
   logic        dprio_rdvalid;

   modport master (
      output dprio_addr, dprio_dataout, dprio_rden, dprio_wren, quad_addr,
      input  dprio_busy, dprio_datain, dprio_rdvalid
   );

   modport slave (
      input  dprio_addr, dprio_dataout, dprio_rden, dprio_wren, quad_addr,
      output dprio_busy, dprio_datain, dprio_rdvalid
   );
endinterface
`default_nettype wire

// File: rtl/alt_cal_dprio_ser_sv_bittimer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alt_cal_dprio_bittimer : bit-time divider, dpclk and strobes         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alt_cal_dprio_bittimer #(
   parameter int CLK_DIV = 2
) (
   input  wire logic clock,
   input  wire logic reset,
   input  wire logic i_en,
   output logic      o_dpclk,
   output logic      o_bit_start,
   output logic      o_sample_strobe
);
   localparam logic [3:0] c_LAST = 4'(CLK_DIV - 1);
   localparam logic [3:0] c_HALF = 4'(CLK_DIV / 2);

   logic [3:0] r_div;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_div <= 4'd0;
      else if (!i_en || (r_div == c_LAST))
         r_div <= 4'd0;
      else
         r_div <= r_div + 4'd1;
   end

   // o_bit_start flags the last clock of a bit so registered users change
   // on the first clock of the next bit; the sample strobe's closing edge
   // is the one that raises dpclk.
   assign o_dpclk         = i_en & (r_div >= c_HALF);
   assign o_bit_start     = i_en & (r_div == c_LAST);
   assign o_sample_strobe = i_en & (r_div == (c_HALF - 4'd1));

endmodule
`default_nettype wire

// File: rtl/alt_cal_dprio_ser_sv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alt_cal_dprio_ser_sv : serial DPRIO master (address + data frames)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alt_cal_dprio_ser_sv
   import alt_cal_sv_pkg::*;
#(
   parameter int CLK_DIV      = 2,
   parameter int PREAMBLE_LEN = 32,
   parameter int GAP_BITS     = 2
) (
   input  wire logic              clock,
   input  wire logic              reset,
   alt_cal_dprio_ser_sv_if.slave  bus,
   output logic                   dpclk,
   output logic                   dprioin,
   input  wire logic              dprioout,
   output logic                   dpriodisable
);
   localparam logic [6:0] c_FRAME_CNT = 7'(PREAMBLE_LEN + c_TAIL_W);
   localparam logic [6:0] c_GAP_CNT   = 7'(GAP_BITS);

   state_t                r_state;
   logic [15:0]           r_addr;
   logic [15:0]           r_wdata;
   logic [4:0]            r_prtad;
   logic [1:0]            r_op;
   logic [6:0]            r_bitcnt;
   logic [15:0]           r_shift;
   logic                  r_busy;
   logic [15:0]           r_datain;
   logic                  r_rdvalid;
   logic                  r_dprioin;
   logic                  r_disable;

   logic                  w_bit_start;
   logic                  w_sample;
   logic [c_TAIL_W-1:0]   w_tail_addr;
   logic [c_TAIL_W-1:0]   w_tail_data;
   logic                  w_unused_quad;

   alt_cal_dprio_bittimer #(.CLK_DIV(CLK_DIV)) u_bittimer (
      .clock           (clock),
      .reset           (reset),
      .i_en            (r_state != ST_IDLE),
      .o_dpclk         (dpclk),
      .o_bit_start     (w_bit_start),
      .o_sample_strobe (w_sample)
   );

   assign w_tail_addr   = frame_tail(OP_ADDR, r_prtad, r_addr);
   assign w_tail_data   = frame_tail(r_op, r_prtad, r_wdata);
   assign w_unused_quad = ^bus.quad_addr[8:5];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_addr    <= 16'd0;
         r_wdata   <= 16'd0;
         r_prtad   <= 5'd0;
         r_op      <= OP_ADDR;
         r_bitcnt  <= 7'd0;
         r_shift   <= 16'd0;
         r_busy    <= 1'b0;
         r_datain  <= 16'd0;
         r_rdvalid <= 1'b0;
         r_dprioin <= 1'b1;
         r_disable <= 1'b1;
      end else begin
         r_rdvalid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.dprio_rden || bus.dprio_wren) begin
                  r_addr    <= bus.dprio_addr;
                  r_wdata   <= bus.dprio_dataout;
                  r_prtad   <= bus.quad_addr[4:0];
                  r_op      <= bus.dprio_wren ? OP_WR : OP_RD;
                  r_busy    <= 1'b1;
                  r_bitcnt  <= c_FRAME_CNT;
                  r_dprioin <= 1'b1;
                  r_disable <= 1'b0;
                  r_state   <= ST_ADDR_FRM;
               end
            end
            ST_ADDR_FRM: begin
               if (w_bit_start) begin
                  if (r_bitcnt == 7'd1) begin
                     r_dprioin <= 1'b1;
                     if (GAP_BITS == 0) begin
                        r_bitcnt <= c_FRAME_CNT;
                        r_state  <= ST_DATA_FRM;
                     end else begin
                        r_bitcnt  <= c_GAP_CNT;
                        r_disable <= 1'b1;
                        r_state   <= ST_GAP;
                     end
                  end else begin
                     r_bitcnt  <= r_bitcnt - 7'd1;
                     r_dprioin <= frame_bit(w_tail_addr, r_bitcnt - 7'd1);
                  end
               end
            end
            ST_GAP: begin
               if (w_bit_start) begin
                  if (r_bitcnt == 7'd1) begin
                     r_bitcnt  <= c_FRAME_CNT;
                     r_dprioin <= 1'b1;
                     r_disable <= 1'b0;
                     r_state   <= ST_DATA_FRM;
                  end else begin
                     r_bitcnt <= r_bitcnt - 7'd1;
                  end
               end
            end
            ST_DATA_FRM: begin
               // The whole frame is shifted; only the trailing DATA16 survives.
               if (w_sample)
                  r_shift <= {r_shift[14:0], dprioout};
               if (w_bit_start) begin
                  if (r_bitcnt == 7'd1) begin
                     r_bitcnt  <= 7'd0;
                     r_dprioin <= 1'b1;
                     r_disable <= 1'b1;
                     if (r_op == OP_RD) begin
                        r_datain  <= r_shift;
                        r_rdvalid <= 1'b1;
                     end
                     r_state <= ST_DONE;
                  end else begin
                     r_bitcnt  <= r_bitcnt - 7'd1;
                     r_dprioin <= frame_bit(w_tail_data, r_bitcnt - 7'd1);
                  end
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy    <= 1'b0;
               r_disable <= 1'b1;
               r_dprioin <= 1'b1;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.dprio_busy    = r_busy;
   assign bus.dprio_datain  = r_datain;
   assign bus.dprio_rdvalid = r_rdvalid;
   assign dprioin           = r_dprioin;
   assign dpriodisable      = r_disable;

endmodule
`default_nettype wire

// File: tb/tb_alt_cal_dprio_ser_sv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alt_cal_dprio_ser_sv : directed bench, frame decoder + device     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alt_cal_dprio_ser_sv;

   logic clk;
   logic rst;
   logic dpclk1, din1, dout1, dis1;
   logic dpclk2, din2, dout2, dis2;
   logic [15:0] tx_word;

   int n_checks;
   int n_fail;

   alt_cal_dprio_ser_sv_if b1 ();
   alt_cal_dprio_ser_sv_if b2 ();

   alt_cal_dprio_ser_sv #(.CLK_DIV(2), .PREAMBLE_LEN(32), .GAP_BITS(2)) u_dut1 (
      .clock(clk), .reset(rst), .bus(b1), .dpclk(dpclk1),
      .dprioin(din1), .dprioout(dout1), .dpriodisable(dis1)
   );

   alt_cal_dprio_ser_sv #(.CLK_DIV(4), .PREAMBLE_LEN(1), .GAP_BITS(0)) u_dut2 (
      .clock(clk), .reset(rst), .bus(b2), .dpclk(dpclk2),
      .dprioin(din2), .dprioout(dout2), .dpriodisable(dis2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Frame decoders: one bit per dpclk rise while the port is enabled.
   int          m1_cnt;
   logic [95:0] m1_sh;
   logic [31:0] m1_tail[$];
   bit          m1_pre[$];
   always @(posedge dpclk1 or posedge rst) begin
      if (rst) m1_cnt = 0;
      else if (!dis1) begin
         m1_sh = {m1_sh[94:0], din1};
         m1_cnt++;
         if (m1_cnt == 64) begin
            m1_tail.push_back(m1_sh[31:0]);
            m1_pre.push_back(m1_sh[63:32] == 32'hFFFF_FFFF);
            m1_cnt = 0;
         end
      end
   end

   int          m2_cnt;
   logic [95:0] m2_sh;
   logic [31:0] m2_tail[$];
   bit          m2_pre[$];
   always @(posedge dpclk2 or posedge rst) begin
      if (rst) m2_cnt = 0;
      else if (!dis2) begin
         m2_sh = {m2_sh[94:0], din2};
         m2_cnt++;
         if (m2_cnt == 33) begin
            m2_tail.push_back(m2_sh[31:0]);
            m2_pre.push_back(m2_sh[32] == 1'b1);
            m2_cnt = 0;
         end
      end
   end

   // Transceiver model: presents the next bit after each dpclk fall.
   always @(negedge dpclk1) begin
      if (m1_cnt >= 48 && m1_cnt <= 63) dout1 = tx_word[4'(63 - m1_cnt)];
      else dout1 = 1'b1;
   end

   int          rv_cnt;
   logic [15:0] rv_data;
   always @(negedge clk) begin
      if (b1.dprio_rdvalid) begin
         rv_cnt++;
         rv_data = b1.dprio_datain;
      end
   end

   int s2_hi, s2_rise, s2_cyc, s2_last, s2_min, s2_max;
   logic s2_prev;
   always @(negedge clk) begin
      if (b2.dprio_busy) begin
         if (dpclk2) s2_hi++;
         if (dpclk2 && !s2_prev) begin
            s2_rise++;
            if (s2_last >= 0) begin
               if (s2_cyc - s2_last < s2_min) s2_min = s2_cyc - s2_last;
               if (s2_cyc - s2_last > s2_max) s2_max = s2_cyc - s2_last;
            end
            s2_last = s2_cyc;
         end
      end
      s2_prev = dpclk2;
      s2_cyc++;
   end

   task automatic clear_mon();
      m1_tail.delete(); m1_pre.delete();
      m2_tail.delete(); m2_pre.delete();
      rv_cnt = 0;
   endtask

   task automatic txn1(input logic [15:0] a, input logic [15:0] d, input logic [8:0] q,
                       input logic wr, input logic rd, input int inj_at, input int abort_at,
                       output int cyc);
      @(negedge clk);
      b1.dprio_addr = a; b1.dprio_dataout = d; b1.quad_addr = q;
      b1.dprio_wren = wr; b1.dprio_rden = rd;
      @(negedge clk);
      b1.dprio_wren = 1'b0; b1.dprio_rden = 1'b0;
      cyc = 0;
      while (b1.dprio_busy && cyc < 2000) begin
         cyc++;
         if (cyc == inj_at) begin
            b1.dprio_wren = 1'b1; b1.dprio_addr = 16'h1111; b1.dprio_dataout = 16'h2222;
         end else if (cyc == inj_at + 1) begin
            b1.dprio_wren = 1'b0;
         end
         if (cyc == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_ctl", {b1.dprio_busy, b1.dprio_rdvalid, dpclk1, din1, dis1}, 32'b00011);
            check("abort_datain", b1.dprio_datain, 32'h0);
            @(negedge clk);
            rst = 1'b0;
         end
         @(negedge clk);
      end
      check("busy_bound", b1.dprio_busy, 0);
      repeat (5) @(negedge clk);
   endtask

   task automatic txn2(input logic [15:0] a, input logic [15:0] d, input logic [8:0] q,
                       output int cyc);
      @(negedge clk);
      b2.dprio_addr = a; b2.dprio_dataout = d; b2.quad_addr = q; b2.dprio_wren = 1'b1;
      @(negedge clk);
      b2.dprio_wren = 1'b0;
      cyc = 0;
      while (b2.dprio_busy && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
      check("busy2_bound", b2.dprio_busy, 0);
      repeat (5) @(negedge clk);
   endtask

   int cyc;

   initial begin
      clk = 1'b0; rst = 1'b1; dout1 = 1'b1; dout2 = 1'b1; tx_word = 16'h0;
      n_checks = 0; n_fail = 0; m1_sh = '0; m2_sh = '0;
      s2_hi = 0; s2_rise = 0; s2_cyc = 0; s2_last = -1; s2_min = 999; s2_max = 0; s2_prev = 1'b0;
      b1.dprio_addr = '0; b1.dprio_dataout = '0; b1.quad_addr = '0; b1.dprio_wren = 0; b1.dprio_rden = 0;
      b2.dprio_addr = '0; b2.dprio_dataout = '0; b2.quad_addr = '0; b2.dprio_wren = 0; b2.dprio_rden = 0;
      clear_mon();
      repeat (3) @(negedge clk);
      check("rst_ctl1", {b1.dprio_busy, b1.dprio_rdvalid, dpclk1, din1, dis1}, 32'b00011);
      check("rst_datain1", b1.dprio_datain, 32'h0);
      check("rst_ctl2", {b2.dprio_busy, b2.dprio_rdvalid, dpclk2, din2, dis2}, 32'b00011);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Write
      clear_mon();
      txn1(16'h0123, 16'hA5C3, 9'h005, 1'b1, 1'b0, 0, 0, cyc);
      check("wr_busy", cyc, 261);
      check("wr_nframes", m1_tail.size(), 2);
      if (m1_tail.size() == 2) begin
         check("wr_addr_frm", m1_tail[0], 32'h0282_0123);
         check("wr_data_frm", m1_tail[1], 32'h1282_A5C3);
         check("wr_preamble", {m1_pre[0], m1_pre[1]}, 2'b11);
      end
      check("wr_no_rdvalid", rv_cnt, 0);

      // Read
      clear_mon();
      tx_word = 16'hBEEF;
      txn1(16'h0040, 16'h0000, 9'h1E3, 1'b0, 1'b1, 0, 0, cyc);
      check("rd_busy", cyc, 261);
      check("rd_nframes", m1_tail.size(), 2);
      if (m1_tail.size() == 2) begin
         check("rd_addr_frm", m1_tail[0], 32'h0182_0040);
         check("rd_data_frm", m1_tail[1], 32'h3183_FFFF);
      end
      check("rd_rdvalid_cnt", rv_cnt, 1);
      check("rd_data_at_valid", rv_data, 32'hBEEF);
      check("rd_datain_hold", b1.dprio_datain, 32'hBEEF);

      // wren and rden together: write wins
      clear_mon();
      txn1(16'h0A0A, 16'h1234, 9'h00F, 1'b1, 1'b1, 0, 0, cyc);
      check("both_nframes", m1_tail.size(), 2);
      if (m1_tail.size() == 2) begin
         check("both_addr_frm", m1_tail[0], 32'h0782_0A0A);
         check("both_data_frm", m1_tail[1], 32'h1782_1234);
      end
      check("both_no_rdvalid", rv_cnt, 0);
      check("both_datain", b1.dprio_datain, 32'hBEEF);

      // Request during busy is dropped
      clear_mon();
      txn1(16'hFFFF, 16'h0000, 9'h000, 1'b1, 1'b0, 50, 0, cyc);
      repeat (300) @(negedge clk);
      check("inj_busy", cyc, 261);
      check("inj_nframes", m1_tail.size(), 2);
      if (m1_tail.size() == 2) begin
         check("inj_addr_frm", m1_tail[0], 32'h0002_FFFF);
         check("inj_data_frm", m1_tail[1], 32'h1002_0000);
      end

      // Reset mid-read, then a clean read
      clear_mon();
      tx_word = 16'hCAFE;
      txn1(16'h0040, 16'h0000, 9'h1E3, 1'b0, 1'b1, 0, 100, cyc);
      check("abort_no_rdvalid", rv_cnt, 0);
      check("abort_nframes", m1_tail.size(), 0);
      clear_mon();
      tx_word = 16'h1357;
      txn1(16'h0040, 16'h0000, 9'h1E3, 1'b0, 1'b1, 0, 0, cyc);
      check("post_busy", cyc, 261);
      check("post_rdvalid_cnt", rv_cnt, 1);
      check("post_datain", b1.dprio_datain, 32'h1357);
      check("post_nframes", m1_tail.size(), 2);

      // CLK_DIV=4, PREAMBLE_LEN=1, GAP_BITS=0
      clear_mon();
      s2_hi = 0; s2_rise = 0; s2_last = -1; s2_min = 999; s2_max = 0;
      txn2(16'h0123, 16'hA5C3, 9'h005, cyc);
      check("d2_busy", cyc, 265);
      check("d2_nframes", m2_tail.size(), 2);
      if (m2_tail.size() == 2) begin
         check("d2_addr_frm", m2_tail[0], 32'h0282_0123);
         check("d2_data_frm", m2_tail[1], 32'h1282_A5C3);
         check("d2_preamble", {m2_pre[0], m2_pre[1]}, 2'b11);
      end
      check("d2_rises", s2_rise, 66);
      check("d2_high_cycles", s2_hi, 132);
      check("d2_period_min", s2_min, 4);
      check("d2_period_max", s2_max, 4);
      check("d2_idle_dpclk", dpclk2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alt_cal_dprio_ser_sv.md
Name: alt_cal_dprio_ser_sv

Overview:
Serial DPRIO master that sits directly downstream of the transceiver calibration controller. It consumes the parallel dprio_addr/dprio_dataout/dprio_rden/dprio_wren/quad_addr requests from the controller and executes each one as two serial frames on the transceiver dynamic-reconfiguration port. The first frame is an address frame and the second is a write or read frame. It returns dprio_busy to the controller, and for reads it also returns dprio_datain.

Parameters:
CLK_DIV, 2, clock cycles per serial bit; legal range 2..15, even values only.
PREAMBLE_LEN, 32, number of '1' preamble bits per frame; legal range 1..32.
GAP_BITS, 2, idle bit-times with dpriodisable high between the address frame and the data frame.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
dprio_addr  in  16  register address from the calibration controller.
dprio_dataout  in  16  write data from the controller.
dprio_rden  in  1  read request; sampled only when dprio_busy=0.
dprio_wren  in  1  write request; sampled only when dprio_busy=0.
quad_addr  in  9  quad address; bits [4:0] form PRTAD, bits [8:5] are ignored.
dprio_busy  out  1  transaction in progress.
dprio_datain  out  16  read data; holds its value until the next read completes.
dprio_rdvalid  out  1  one-cycle pulse when dprio_datain has been updated.
dpclk  out  1  serial clock to the transceiver.
dprioin  out  1  serial data to the transceiver (MSB first).
dprioout  in  1  serial data from the transceiver.
dpriodisable  out  1  port disable, high when idle.

Behaviour:
- Reset values (asynchronous): dprio_busy=0, dprio_datain=0, dprio_rdvalid=0, dpclk=0, dprioin=1, dpriodisable=1. State = IDLE and all counters = 0.
- Reset asserted mid-transaction aborts it immediately. No dprio_rdvalid is generated, and no partial data reaches dprio_datain.
- Bit timing:
  - A bit-time is CLK_DIV clocks.
  - dpclk is low for the first CLK_DIV/2 clocks of the bit-time and high for the rest.
  - dprioin updates on the first clock of each bit-time.
  - dprioout is sampled on the clock where dpclk rises.
- Frame format, PREAMBLE_LEN+32 bits:
  - Preamble: all 1s.
  - ST = 00.
  - OP: address=00, write=01, read=11.
  - PRTAD = quad_addr[4:0], DEVAD = 5'b00000.
  - TA = 10 for address and write frames. For read frames, dprioin=1 during TA.
  - DATA16: dprio_addr for the address frame, dprio_dataout for the write frame, captured from dprioout for the read frame.
- Request acceptance:
  - In IDLE, a request (dprio_rden|dprio_wren) registers dprio_addr, dprio_dataout, quad_addr and the opcode.
  - dprio_busy goes to 1 on the next clock edge.
  - wren and rden asserted together: the write wins and the read is dropped.
  - Requests arriving while dprio_busy=1 are ignored and are not queued.
- State machine:
  - IDLE -> ADDR_FRM on request; dpriodisable drops in the same cycle as the first preamble bit.
  - ADDR_FRM -> GAP after the last bit; dpriodisable=1 and dprioin=1 for GAP_BITS bit-times.
  - GAP -> DATA_FRM.
  - DATA_FRM -> DONE after the last bit.
  - DONE lasts 1 clock:
    - For reads, dprio_datain is loaded and dprio_rdvalid is pulsed.
    - dpriodisable returns to 1.
    - dprio_busy clears at the end of DONE.
  - DONE -> IDLE.
  - If GAP_BITS=0, GAP is skipped.
- Latency: busy duration = (2*(PREAMBLE_LEN+32)+GAP_BITS)*CLK_DIV + 1 clocks. With defaults: (128+2)*2+1 = 261 clocks.
- Counters:
  - Divider counter width = 4.
  - Bit counter width = 7; it counts down from frame length to 0 and does not wrap.
  - Read shift register is 16 bits, shifted left, with the LSB filled from dprioout.
- dpclk stops low whenever the state is IDLE.

Decomposition:
- Shared package alt_cal_sv_pkg holds:
  - Opcode constants OP_ADDR / OP_WR / OP_RD.
  - State enum.
  - Frame field widths: ST=2, OP=2, PRT=5, DEV=5, TA=2, DATA=16.
- One sub-module, alt_cal_dprio_bittimer: divider producing the dpclk, bit_start and sample_strobe signals. It is enabled only outside IDLE.

Test Plan:
- Write: addr=16'h0123, data=16'hA5C3, quad_addr=9'h005, wren pulse.
  - Bench decodes two frames: OP=00/DATA=0123 and OP=01/DATA=A5C3, both with PRTAD=00101.
  - dprio_busy is high for exactly 261 clocks.
- Read: addr=16'h0040, bench model drives 16'hBEEF on dprioout during the DATA field.
  - dprio_datain=BEEF and dprio_rdvalid is a single 1-cycle pulse at DONE.
  - dprioin=1 during TA.
- Simultaneous wren+rden: a write frame is emitted (OP=01), no dprio_rdvalid, dprio_datain unchanged.
- Request during busy: wren pulsed at clock 50 of a transaction is ignored; exactly 2 frames are observed in total.
- Reset at clock 100 of a read: outputs return to reset values asynchronously, no rdvalid. A subsequent read completes normally.
- CLK_DIV=4, PREAMBLE_LEN=1, GAP_BITS=0: busy = 2*33*4+1 = 265 clocks; dpclk period is 4 clocks with 50% duty.
